// File: rtl/fpu_link_pkg.sv
// Shared types and word packing for the host side of the calculator pin protocol.
// Every frame word on inp is {tag[1:0], payload[9:0]}.
package fpu_link_pkg;

    localparam int DATA_W = 10;
    localparam int OP_W   = 4;
    localparam int BUS_W  = 12;

    typedef enum logic [1:0] {
        TAG_IDLE = 2'b00,
        TAG_A    = 2'b01,
        TAG_B    = 2'b10,
        TAG_OP   = 2'b11
    } tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_GAP_AB,
        ST_SEND_B,
        ST_GAP_BO,
        ST_SEND_OP,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [BUS_W-1:0] pack_word(input tag_t tag, input logic [DATA_W-1:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable saturating down-counter; expired is high whenever the count sits at zero.
// One instance times both the inter-beat gaps and the result timeout.
module link_timer #(
    parameter int W = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/fpu_host_link.sv
// Host-side driver for the calculator: serialises {a, b, op} onto inp as tagged words,
// then waits for done (or a timeout) and returns the result on a valid/ready port.
module fpu_host_link
    import fpu_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OP_W-1:0]   req_op,
    output logic [BUS_W-1:0]  inp,
    input  logic [DATA_W-1:0] out,
    input  logic              done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_timeout,
    output logic              busy
);

    // The counter also has to hold the gap length, which may exceed the timeout.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [BUS_W-1:0]    inp_q, inp_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic                timer_load;
    logic [CNT_W-1:0]    timer_load_val;
    logic                timer_en;
    logic                timer_expired;

    link_timer #(
        .W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_timeout_d  = rsp_timeout_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_SEND_A;
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                end
            end
            ST_SEND_A: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_SEND_B;
                end else begin
                    state_d        = ST_GAP_AB;
                    timer_load     = 1'b1;
                    timer_load_val = GAP_LOAD;
                end
            end
            ST_GAP_AB: begin
                timer_en = 1'b1;
                if (timer_expired) state_d = ST_SEND_B;
            end
            ST_SEND_B: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_SEND_OP;
                end else begin
                    state_d        = ST_GAP_BO;
                    timer_load     = 1'b1;
                    timer_load_val = GAP_LOAD;
                end
            end
            ST_GAP_BO: begin
                timer_en = 1'b1;
                if (timer_expired) state_d = ST_SEND_OP;
            end
            ST_SEND_OP: begin
                state_d        = ST_WAIT;
                timer_load     = 1'b1;
                timer_load_val = WAIT_LOAD;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                // A done in the final timeout cycle still delivers the real result.
                if (done) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = out;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = '0;
                    rsp_timeout_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // inp is registered from the next state so each beat appears the cycle its state is entered.
        unique case (state_d)
            ST_SEND_A:  inp_d = pack_word(TAG_A, a_d);
            ST_SEND_B:  inp_d = pack_word(TAG_B, b_d);
            ST_SEND_OP: inp_d = pack_word(TAG_OP, {{(DATA_W-OP_W){1'b0}}, op_d});
            default:    inp_d = pack_word(TAG_IDLE, '0);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            inp_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            inp_q         <= inp_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign inp         = inp_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);

endmodule
